// File: rtl/iter_arith_unit_pkg.sv
// Shared types and default widths for the iterative sqrt / divide unit.
package arith_pkg;

    localparam int N_W_DEF = 16;
    localparam int D_W_DEF = 8;
    localparam int F_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic {
        MODE_SQRT = 1'b0,
        MODE_DIV  = 1'b1
    } mode_e;

endpackage

// File: rtl/iter_arith_unit_if.sv
// Start/done handshake and operand/result bus between the core and the unit.
interface iter_arith_unit_if
    import arith_pkg::*;
#(
    parameter int N_W = N_W_DEF,
    parameter int D_W = D_W_DEF,
    parameter int F_W = F_W_DEF
);
    localparam int R_W = N_W + F_W;

    logic           start;
    logic           mode;
    logic [N_W-1:0] operand_a;
    logic [D_W-1:0] operand_b;
    logic           busy;
    logic           done;
    logic [R_W-1:0] result;
    logic           dbz;

    modport master (output start, mode, operand_a, operand_b,
                    input  busy, done, result, dbz);
    modport slave  (input  start, mode, operand_a, operand_b,
                    output busy, done, result, dbz);
endinterface

// File: rtl/iter_arith_unit_round.sv
// Saturating half-up incrementer: adds one when enabled and requested, never past i_max.
module arith_round #(
    parameter int W = 24
) (
    input  logic         i_en,
    input  logic         i_inc,
    input  logic [W-1:0] i_value,
    input  logic [W-1:0] i_max,
    output logic [W-1:0] o_value
);
    // Increment only while below the saturation limit.
    always_comb begin
        if (i_en && i_inc && (i_value < i_max)) begin
            o_value = i_value + W'(1);
        end else begin
            o_value = i_value;
        end
    end
endmodule

// File: rtl/iter_arith_unit.sv
// Iterative rounded sqrt / fixed-point divide co-processor.
// Build option ITER_ARITH_ROUND_EN enables half-up rounding in the ROUND state.
module iter_arith_unit
    import arith_pkg::*;
#(
    parameter int N_W = N_W_DEF,
    parameter int D_W = D_W_DEF,
    parameter int F_W = F_W_DEF
) (
    input logic              CLK,
    input logic              RST_N,
    iter_arith_unit_if.slave bus
);
    localparam int R_W   = N_W + F_W;
    localparam int Q_W   = R_W + 1;
    localparam int H_W   = N_W / 2;
    localparam int REM_W = N_W + 2;
    localparam int CNT_W = $clog2(Q_W + 1);
    localparam logic [CNT_W-1:0] SQRT_ITER = CNT_W'(H_W);
    localparam logic [CNT_W-1:0] DIV_ITER  = CNT_W'(Q_W);

    state_e           r_state, w_state_nxt;
    mode_e            r_mode;
    logic [D_W-1:0]   r_divisor;
    logic [Q_W-1:0]   r_shift, r_acc, w_acc_nxt;
    logic [REM_W-1:0] r_rem, w_rem_sh, w_trial, w_rem_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy, r_done, r_dbz, w_fits;
    logic [R_W-1:0]   r_result;
    logic [R_W-1:0]   w_rnd_in, w_rnd_max, w_rnd_out;
    logic             w_rnd_inc, w_rnd_en;

`ifdef ITER_ARITH_ROUND_EN
    assign w_rnd_en = 1'b1;
`else
    assign w_rnd_en = 1'b0;
`endif

    // One restoring step: sqrt brings down two radicand bits, divide brings down one.
    always_comb begin
        w_rem_sh  = '0;
        w_trial   = '0;
        w_rnd_in  = '0;
        w_rnd_max = '1;
        w_rnd_inc = 1'b0;
        if (r_mode == MODE_SQRT) begin
            w_rem_sh  = {r_rem[REM_W-3:0], r_shift[Q_W-1 -: 2]};
            w_trial   = {r_acc[REM_W-3:0], 2'b01};
            w_rnd_in  = R_W'(r_acc[H_W-1:0]);
            w_rnd_max = R_W'({H_W{1'b1}});
            w_rnd_inc = (r_rem > REM_W'(r_acc[H_W-1:0]));
        end else begin
            w_rem_sh  = {r_rem[REM_W-2:0], r_shift[Q_W-1]};
            w_trial   = REM_W'(r_divisor);
            w_rnd_in  = r_acc[Q_W-1:1];
            w_rnd_max = '1;
            w_rnd_inc = r_acc[0];
        end
        w_fits    = (w_rem_sh >= w_trial);
        w_rem_nxt = w_fits ? (w_rem_sh - w_trial) : w_rem_sh;
        w_acc_nxt = {r_acc[Q_W-2:0], w_fits};
    end

    arith_round #(.W(R_W)) u_round (
        .i_en    (w_rnd_en),
        .i_inc   (w_rnd_inc),
        .i_value (w_rnd_in),
        .i_max   (w_rnd_max),
        .o_value (w_rnd_out)
    );

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = bus.start ? RUN : IDLE;
            RUN:     w_state_nxt = (r_cnt == CNT_W'(1)) ? ROUND : RUN;
            ROUND:   w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand capture, iteration datapath and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_mode    <= MODE_SQRT;
            r_divisor <= '0;
            r_shift   <= '0;
            r_acc     <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
            r_result  <= '0;
        end else begin
            r_busy <= (w_state_nxt != IDLE);
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_mode    <= mode_e'(bus.mode);
                        r_divisor <= bus.operand_b;
                        r_shift   <= {bus.operand_a, {(F_W+1){1'b0}}};
                        r_acc     <= '0;
                        r_rem     <= '0;
                        r_cnt     <= bus.mode ? DIV_ITER : SQRT_ITER;
                        r_result  <= '0;
                        r_dbz     <= 1'b0;
                    end
                end
                RUN: begin
                    r_rem   <= w_rem_nxt;
                    r_acc   <= w_acc_nxt;
                    r_cnt   <= r_cnt - CNT_W'(1);
                    r_shift <= (r_mode == MODE_SQRT) ? {r_shift[Q_W-3:0], 2'b00}
                                                     : {r_shift[Q_W-2:0], 1'b0};
                end
                ROUND: begin
                    r_done <= 1'b1;
                    if ((r_mode == MODE_DIV) && (r_divisor == '0)) begin
                        r_result <= '1;
                        r_dbz    <= 1'b1;
                    end else begin
                        r_result <= w_rnd_out;
                        r_dbz    <= 1'b0;
                    end
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.dbz    = r_dbz;

endmodule

// File: tb/tb_iter_arith_unit.sv
// Self-checking bench for iter_arith_unit: directed table, random ops vs. a reference model, corner sequences.
module tb_iter_arith_unit;

`ifdef ITER_ARITH_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST_N = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 CLK = ~CLK;

    iter_arith_unit_if #(.N_W(16), .D_W(8), .F_W(8)) bus ();

    iter_arith_unit #(.N_W(16), .D_W(8), .F_W(8)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    typedef struct {
        logic        m;
        logic [15:0] a;
        logic [7:0]  b;
        logic [23:0] res;
        logic        dbz;
        int          lat;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: integer sqrt by search and divide by plain arithmetic, rounding applied afterwards.
    function automatic logic [24:0] model(input logic m, input logic [15:0] a, input logic [7:0] b);
        longint r, rem, q;
        if (m == 1'b0) begin
            r = 0;
            while ((r + 1) * (r + 1) <= longint'(a)) r++;
            rem = longint'(a) - r * r;
            if (ROUND_EN && rem > r && r < 255) r++;
            return {1'b0, 24'(r)};
        end
        if (b == 8'd0) return {1'b1, 24'hFFFFFF};
        q = (longint'(a) * 512) / longint'(b);
        r = q / 2;
        if (ROUND_EN && (q % 2) == 1) r++;
        if (r > 64'h0000_0000_00FF_FFFF) r = 64'h0000_0000_00FF_FFFF;
        return {1'b0, 24'(r)};
    endfunction

    // Present one request for one cycle at a falling edge; returns on the falling edge after acceptance.
    task automatic issue(input logic m, input logic [15:0] a, input logic [7:0] b);
        bus.start     = 1'b1;
        bus.mode      = m;
        bus.operand_a = a;
        bus.operand_b = b;
        @(negedge CLK);
        bus.start     = 1'b0;
        bus.mode      = 1'($urandom);
        bus.operand_a = 16'($urandom);
        bus.operand_b = 8'($urandom);
    endtask

    // lat counts cycles from the start cycle to the done cycle; busy_low counts busy dropouts meanwhile.
    task automatic wait_done(output int lat, output int busy_low);
        lat = 1;
        busy_low = 0;
        forever begin
            if (bus.busy !== 1'b1) busy_low++;
            if (bus.done === 1'b1 || lat >= 200) break;
            @(negedge CLK);
            lat++;
        end
        if (bus.done !== 1'b1) begin
            errors++;
            checks++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected done", lat);
        end
    endtask

    task automatic run_check(input string name, input logic m, input logic [15:0] a, input logic [7:0] b,
                             input logic [23:0] exp_res, input logic exp_dbz, input int exp_lat);
        int lat, bl;
        issue(m, a, b);
        wait_done(lat, bl);
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_busy_low"}, bl, 0);
        check({name, "_result"}, bus.result, exp_res);
        check({name, "_dbz"}, bus.dbz, exp_dbz);
        @(negedge CLK);
        check({name, "_done_pulse"}, bus.done, 0);
        check({name, "_busy_after"}, bus.busy, 0);
        check({name, "_result_hold"}, bus.result, exp_res);
    endtask

    initial begin
        int lat, bl, ndone;
        logic [23:0] res_at_done;
        logic [24:0] exp;
        logic        rm;
        logic [15:0] ra;
        logic [7:0]  rb;

        vecs[0] = '{1'b0, 16'd241,   8'd0, ROUND_EN ? 24'h000010 : 24'h00000F, 1'b0, 10};
        vecs[1] = '{1'b0, 16'hFFFF,  8'd0, 24'h0000FF, 1'b0, 10};
        vecs[2] = '{1'b0, 16'd0,     8'd0, 24'h000000, 1'b0, 10};
        vecs[3] = '{1'b0, 16'd240,   8'd0, 24'h00000F, 1'b0, 10};
        vecs[4] = '{1'b1, 16'd100,   8'd7, 24'h000E49, 1'b0, 27};
        vecs[5] = '{1'b1, 16'd1,     8'd3, 24'h000055, 1'b0, 27};
        vecs[6] = '{1'b1, 16'h1234,  8'd0, 24'hFFFFFF, 1'b1, 27};
        vecs[7] = '{1'b1, 16'hFFFF,  8'd1, 24'hFFFF00, 1'b0, 27};

        bus.start = 1'b0;
        bus.mode = 1'b0;
        bus.operand_a = '0;
        bus.operand_b = '0;
        #2 RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_result", bus.result, 0);
        check("reset_dbz", bus.dbz, 0);
        RST_N = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < 8; i++) begin
            run_check($sformatf("vec%0d", i), vecs[i].m, vecs[i].a, vecs[i].b,
                      vecs[i].res, vecs[i].dbz, vecs[i].lat);
        end

        for (int i = 0; i < 30; i++) begin
            rm = 1'($urandom);
            ra = 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            exp = model(rm, ra, rb);
            run_check($sformatf("rand%0d", i), rm, ra, rb, exp[23:0], exp[24], rm ? 27 : 10);
        end

        // start re-pulsed while busy must be ignored.
        issue(1'b1, 16'd100, 8'd7);
        ndone = 0;
        res_at_done = '0;
        for (int i = 0; i < 40; i++) begin
            bus.start = (i == 3 || i == 10 || i == 20) ? 1'b1 : 1'b0;
            bus.mode = 1'b0;
            bus.operand_a = 16'd241;
            @(negedge CLK);
            if (bus.done === 1'b1) begin
                ndone++;
                res_at_done = bus.result;
            end
        end
        bus.start = 1'b0;
        check("repulse_done_count", ndone, 1);
        check("repulse_result", res_at_done, 24'h000E49);
        check("repulse_result_hold", bus.result, 24'h000E49);
        check("repulse_idle", bus.busy, 0);

        // start held high: re-accepted on the edge after DONE->IDLE.
        bus.start = 1'b1;
        bus.mode = 1'b0;
        bus.operand_a = 16'd241;
        @(negedge CLK);
        wait_done(lat, bl);
        check("held_lat1", lat, 10);
        check("held_res1", bus.result, vecs[0].res);
        @(negedge CLK);
        check("held_idle_busy", bus.busy, 0);
        check("held_idle_done", bus.done, 0);
        @(negedge CLK);
        check("held_reaccept_busy", bus.busy, 1);
        check("held_reaccept_clear", bus.result, 0);
        bus.start = 1'b0;
        wait_done(lat, bl);
        check("held_lat2", lat, 10);
        check("held_busy2", bl, 0);
        check("held_res2", bus.result, vecs[0].res);
        @(negedge CLK);

        // Reset mid-divide discards the operation immediately.
        issue(1'b1, 16'h1234, 8'd0);
        repeat (10) @(negedge CLK);
        check("midrst_busy_before", bus.busy, 1);
        RST_N = 1'b0;
        #1;
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.done, 0);
        check("midrst_result", bus.result, 0);
        check("midrst_dbz", bus.dbz, 0);
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
        end
        check("midrst_no_done", ndone, 0);
        run_check("post_rst_sqrt241", 1'b0, 16'd241, 8'd0, vecs[0].res, 1'b0, 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
